acq_sequencer: RTL
==================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 10: idle clk cycles between consecutive driver commands.
REQ-002 SHALL have parameter CMD_TIMEOUT, default 4096: max clk cycles from command issue to completion.
REQ-003 SHALL have one clock and a synchronous, active-low reset:
- clk  in  1  FPGA clock; all logic on posedge.
- rstn  in  1  synchronous active-low reset.
REQ-004 SHALL have these run-control and configuration ports:
- run_start  in  1  one-cycle pulse; begins an acquisition run.
- abort  in  1  level; terminates the run.
- cfg_mask  in  8  trigger channel mask written to peripheral reg 0x01.
- cfg_wait_cycles  in  16  acquisition window, in clk cycles.
- cfg_read_addr  in  8  first register address to read back.
- cfg_num_regs  in  8  number of registers to read.
REQ-005 SHALL have these SPI_driver ports:
- new_command  out  1  command strobe.
- is_write  out  1  1 = write, 0 = read.
- write_register_addr  out  8  write address.
- write_data  out  8  write data.
- start_read_register_addr  out  8  read start address.
- num_regs_to_read  out  8  read count.
- write_complete  in  1  driver write done.
- read_complete  in  1  driver read done.
REQ-006 SHALL have these status ports:
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse on successful run end.
- error  out  1  sticky command timeout.
- aborted  out  1  sticky abort flag.
- step  out  3  current sequence step, encoded per REQ-009.

Function
REQ-007 SHALL latch all cfg_* inputs on an accepted run_start and use only the latched copies for the rest of the run.
REQ-008 SHALL accept run_start only in IDLE; run_start while busy=1 SHALL be ignored.
REQ-009 SHALL execute these steps in order:
- 0 IDLE.
- 1 RST: write 0x02 <- 0x01.
- 2 MASK: write 0x01 <- cfg_mask.
- 3 START: write 0x02 <- 0x03.
- 4 ACQ: wait cfg_wait_cycles.
- 5 READOUT: write 0x02 <- 0x02.
- 6 READ: read cfg_num_regs registers from cfg_read_addr.
REQ-010 Each command step SHALL pass through these phases: ISSUE -> WAIT_CPL -> GAP.
REQ-011 ISSUE SHALL drive new_command=1 for exactly 2 clk cycles, with address, data, count and is_write stable from the first ISSUE cycle through the end of WAIT_CPL.
REQ-012 In ISSUE, unused fields SHALL be driven to 0: num_regs_to_read and start_read_register_addr on writes; write_register_addr and write_data on reads.
REQ-013 WAIT_CPL SHALL end on a rising edge of the matching completion input (write_complete for writes, read_complete for reads), detected against a registered copy of that input; an input already high on entry SHALL NOT count as completion.
REQ-014 GAP SHALL hold new_command=0 for exactly GAP_CYCLES clk cycles, then advance to the next step.
REQ-015 After the READ step's GAP, the block SHALL assert done for 1 cycle and return to IDLE.
REQ-016 ACQ SHALL count cfg_wait_cycles clk cycles; cfg_wait_cycles=0 SHALL skip ACQ and go directly to READOUT ISSUE.
REQ-017 cfg_num_regs=0 SHALL skip the READ step; done SHALL then follow READOUT's GAP.
REQ-018 A timeout counter SHALL run in ISSUE+WAIT_CPL; reaching CMD_TIMEOUT cycles SHALL set error=1, force new_command=0, and return to IDLE without asserting done.
REQ-019 abort=1 in any non-IDLE state SHALL, on the next cycle, force new_command=0, set aborted=1, and return to IDLE without asserting done.
REQ-020 If abort and a completion edge occur in the same cycle, abort SHALL take priority.
REQ-021 error and aborted SHALL clear on the next accepted run_start.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 step SHALL reflect the current step and read 0 in IDLE.
REQ-024 The ACQ counter and GAP counter SHALL NOT wrap: each stops at its terminal count and is reloaded on entry to its state.

Reset
REQ-025 With rstn=0 sampled at posedge clk, the block SHALL enter IDLE.
REQ-026 Reset SHALL drive these outputs to 0: new_command, is_write, all address/data/count outputs, busy, done, error, aborted, step.
REQ-027 Reset asserted mid-run SHALL take effect on that edge, overriding every other condition.

Verification
REQ-028 Nominal: cfg_mask=0xF0, wait=20, read_addr=0x0B, num=2 -> writes (02,01), (01,F0), (02,03), then 20-cycle wait, write (02,02), read 0x0B x2, done pulse; each command has 2-cycle new_command and 10-cycle gaps.
REQ-029 Timeout: write_complete held at 0 -> error=1 after 4096 cycles in RST step, busy=0, no done.
REQ-030 Abort during ACQ -> next cycle busy=0, aborted=1, no READOUT write issued; subsequent run_start clears aborted.
REQ-031 Boundary: wait=0 and num=0 -> READOUT ISSUE immediately follows START's GAP, no read issued, done after READOUT's GAP.
REQ-032 run_start pulsed while busy with different cfg values -> ignored; run completes using the originally latched values.
REQ-033 rstn=0 during READ WAIT_CPL -> all outputs 0 at the next edge; a new run after reset completes normally.

Source files
------------

// File: rtl/acq_sequencer.sv
// acq_sequencer: drives a peripheral through reset, mask, start, acquisition
// window and register readout by issuing commands to an SPI command driver.
// Each command goes ISSUE (2-cycle strobe) -> WAIT_CPL (completion edge) -> GAP.
module acq_sequencer #(
    parameter int GAP_CYCLES  = 10,
    parameter int CMD_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        run_start,
    input  logic        abort,
    input  logic [7:0]  cfg_mask,
    input  logic [15:0] cfg_wait_cycles,
    input  logic [7:0]  cfg_read_addr,
    input  logic [7:0]  cfg_num_regs,
    output logic        new_command,
    output logic        is_write,
    output logic [7:0]  write_register_addr,
    output logic [7:0]  write_data,
    output logic [7:0]  start_read_register_addr,
    output logic [7:0]  num_regs_to_read,
    input  logic        write_complete,
    input  logic        read_complete,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        aborted,
    output logic [2:0]  step
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_ACQ
    } state_t;

    typedef struct packed {
        logic       wr;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic [7:0] raddr;
        logic [7:0] nregs;
    } cmd_t;

    localparam logic [2:0] STEP_IDLE    = 3'd0;
    localparam logic [2:0] STEP_RST     = 3'd1;
    localparam logic [2:0] STEP_MASK    = 3'd2;
    localparam logic [2:0] STEP_START   = 3'd3;
    localparam logic [2:0] STEP_ACQ     = 3'd4;
    localparam logic [2:0] STEP_READOUT = 3'd5;
    localparam logic [2:0] STEP_READ    = 3'd6;

    // Counters hold 0..N-1 and leave their state at N-1, so they never wrap.
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;

    state_t       state_q;
    logic [2:0]   step_q;
    cmd_t         cmd_q;
    logic         nc_q;
    logic         busy_q;
    logic         done_q;
    logic         error_q;
    logic         aborted_q;
    logic         issue_q;
    logic [TW-1:0] tmo_q;
    logic [GW-1:0] gap_q;
    logic [15:0]  acq_q;
    logic [7:0]   mask_q;
    logic [15:0]  wait_q;
    logic [7:0]   raddr_q;
    logic [7:0]   nregs_q;
    logic         wc_q;
    logic         rc_q;
    logic [2:0]   next_step_d;
    logic         cpl_edge;

    // Command fields for a step; fields unused by the command type stay zero.
    function automatic cmd_t cmd_for(input logic [2:0] s, input logic [7:0] mask,
                                     input logic [7:0] raddr, input logic [7:0] nregs);
        cmd_t c;
        c = '0;
        case (s)
            STEP_RST:     begin c.wr = 1'b1; c.waddr = 8'h02; c.wdata = 8'h01; end
            STEP_MASK:    begin c.wr = 1'b1; c.waddr = 8'h01; c.wdata = mask;  end
            STEP_START:   begin c.wr = 1'b1; c.waddr = 8'h02; c.wdata = 8'h03; end
            STEP_READOUT: begin c.wr = 1'b1; c.waddr = 8'h02; c.wdata = 8'h02; end
            STEP_READ:    begin c.raddr = raddr; c.nregs = nregs;              end
            default:      c = '0;
        endcase
        return c;
    endfunction

    // A completion only counts as a 0->1 transition of the matching input.
    assign cpl_edge = cmd_q.wr ? (write_complete & ~wc_q) : (read_complete & ~rc_q);

    // Step that follows the current command step once its gap has elapsed.
    always_comb begin
        next_step_d = STEP_IDLE;
        case (step_q)
            STEP_RST:     next_step_d = STEP_MASK;
            STEP_MASK:    next_step_d = STEP_START;
            STEP_START:   next_step_d = (wait_q == 16'd0) ? STEP_READOUT : STEP_ACQ;
            STEP_READOUT: next_step_d = (nregs_q == 8'd0) ? STEP_IDLE : STEP_READ;
            default:      next_step_d = STEP_IDLE;
        endcase
    end

    // Sequencer FSM: reset beats abort beats timeout beats normal progress.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            step_q    <= STEP_IDLE;
            cmd_q     <= '0;
            nc_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            issue_q   <= 1'b0;
            tmo_q     <= '0;
            gap_q     <= '0;
            acq_q     <= '0;
            mask_q    <= '0;
            wait_q    <= '0;
            raddr_q   <= '0;
            nregs_q   <= '0;
            wc_q      <= 1'b0;
            rc_q      <= 1'b0;
        end else begin
            wc_q   <= write_complete;
            rc_q   <= read_complete;
            done_q <= 1'b0;
            if (state_q != S_IDLE && abort) begin
                state_q   <= S_IDLE;
                step_q    <= STEP_IDLE;
                cmd_q     <= '0;
                nc_q      <= 1'b0;
                busy_q    <= 1'b0;
                aborted_q <= 1'b1;
            end else if ((state_q == S_ISSUE || state_q == S_WAIT) &&
                         tmo_q == TW'(CMD_TIMEOUT - 1)) begin
                state_q <= S_IDLE;
                step_q  <= STEP_IDLE;
                cmd_q   <= '0;
                nc_q    <= 1'b0;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (run_start) begin
                            mask_q    <= cfg_mask;
                            wait_q    <= cfg_wait_cycles;
                            raddr_q   <= cfg_read_addr;
                            nregs_q   <= cfg_num_regs;
                            error_q   <= 1'b0;
                            aborted_q <= 1'b0;
                            state_q   <= S_ISSUE;
                            step_q    <= STEP_RST;
                            cmd_q     <= cmd_for(STEP_RST, cfg_mask, cfg_read_addr, cfg_num_regs);
                            nc_q      <= 1'b1;
                            busy_q    <= 1'b1;
                            issue_q   <= 1'b0;
                            tmo_q     <= '0;
                        end
                    end
                    S_ISSUE: begin
                        tmo_q <= tmo_q + TW'(1);
                        if (issue_q) begin
                            state_q <= S_WAIT;
                            nc_q    <= 1'b0;
                        end else begin
                            issue_q <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        tmo_q <= tmo_q + TW'(1);
                        if (cpl_edge) begin
                            state_q <= S_GAP;
                            gap_q   <= '0;
                        end
                    end
                    S_GAP: begin
                        if (gap_q == GW'(GAP_CYCLES - 1)) begin
                            if (next_step_d == STEP_IDLE) begin
                                state_q <= S_IDLE;
                                step_q  <= STEP_IDLE;
                                cmd_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else if (next_step_d == STEP_ACQ) begin
                                state_q <= S_ACQ;
                                step_q  <= STEP_ACQ;
                                acq_q   <= '0;
                            end else begin
                                state_q <= S_ISSUE;
                                step_q  <= next_step_d;
                                cmd_q   <= cmd_for(next_step_d, mask_q, raddr_q, nregs_q);
                                nc_q    <= 1'b1;
                                issue_q <= 1'b0;
                                tmo_q   <= '0;
                            end
                        end else begin
                            gap_q <= gap_q + GW'(1);
                        end
                    end
                    S_ACQ: begin
                        if (acq_q == wait_q - 16'd1) begin
                            state_q <= S_ISSUE;
                            step_q  <= STEP_READOUT;
                            cmd_q   <= cmd_for(STEP_READOUT, mask_q, raddr_q, nregs_q);
                            nc_q    <= 1'b1;
                            issue_q <= 1'b0;
                            tmo_q   <= '0;
                        end else begin
                            acq_q <= acq_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        step_q  <= STEP_IDLE;
                        cmd_q   <= '0;
                        nc_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign new_command              = nc_q;
    assign is_write                 = cmd_q.wr;
    assign write_register_addr      = cmd_q.waddr;
    assign write_data               = cmd_q.wdata;
    assign start_read_register_addr = cmd_q.raddr;
    assign num_regs_to_read         = cmd_q.nregs;
    assign busy                     = busy_q;
    assign done                     = done_q;
    assign error                    = error_q;
    assign aborted                  = aborted_q;
    assign step                     = step_q;

endmodule
